// File: rtl/ecc_load_ctrl.sv
// ecc_load_ctrl: sequences one processor load through the cache read port and an
// external SEC-DED decoder.
//  - Clean word: returned as read.
//  - Single-bit error: the corrected word is written back to the cache (scrub)
//    before the response is returned, and the event is counted.
//  - Double-bit error: the raw word is returned with o_resp_ded set.
//  - Special loads skip all ECC handling.
// Only one load is in flight at a time.
//
// Ports
//  i_clk, i_rst_n                     clock, async active-low reset
//  i_req_valid/o_req_ready            load request handshake (ready only in idle)
//  i_req_addr, i_req_special          load address, ECC-bypass flag
//  o_cache_rd_req/_addr, i_cache_rd_valid, i_cache_data, i_cache_parity
//                                     cache read port
//  o_dec_data, o_dec_parity           captured word and check bits sent to the decoder
//  i_dec_corr_data, i_dec_single, i_dec_double
//                                     decoder results, sampled only in the check state
//  o_cache_wr_req/_addr/_data, i_cache_wr_ack
//                                     scrub write port
//  o_resp_valid/i_resp_ready, o_resp_data, o_resp_ded
//                                     load response handshake
//  o_sec_count, i_cnt_clr             saturating corrected-load counter, sync clear
module ecc_load_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PAR_W  = 7,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_special,
  output logic              o_cache_rd_req,
  output logic [ADDR_W-1:0] o_cache_rd_addr,
  input  logic              i_cache_rd_valid,
  input  logic [DATA_W-1:0] i_cache_data,
  input  logic [PAR_W-1:0]  i_cache_parity,
  output logic [DATA_W-1:0] o_dec_data,
  output logic [PAR_W-1:0]  o_dec_parity,
  input  logic [DATA_W-1:0] i_dec_corr_data,
  input  logic              i_dec_single,
  input  logic              i_dec_double,
  output logic              o_cache_wr_req,
  output logic [ADDR_W-1:0] o_cache_wr_addr,
  output logic [DATA_W-1:0] o_cache_wr_data,
  input  logic              i_cache_wr_ack,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_resp_ded,
  output logic [CNT_W-1:0]  o_sec_count,
  input  logic              i_cnt_clr
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StChk,
    StScrub,
    StRsp
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_special;
  logic                r_rd_req;
  logic [DATA_W-1:0]   r_dec_data;
  logic [PAR_W-1:0]    r_dec_parity;
  logic                r_wr_req;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_ded;
  logic [CNT_W-1:0]    r_cnt;

  // A corrected load: single error flagged, not masked by special or double.
  logic w_sec_inc;
  assign w_sec_inc = (r_state == StChk) && !r_special && !i_dec_double && i_dec_single;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_special    <= 1'b0;
      r_rd_req     <= 1'b0;
      r_dec_data   <= '0;
      r_dec_parity <= '0;
      r_wr_req     <= 1'b0;
      r_wr_data    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_ded   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_addr    <= i_req_addr;
            r_special <= i_req_special;
            r_rd_req  <= 1'b1;
            r_state   <= StRd;
          end
        end
        StRd: begin
          if (i_cache_rd_valid) begin
            r_dec_data   <= i_cache_data;
            r_dec_parity <= i_cache_parity;
            r_rd_req     <= 1'b0;
            r_state      <= StChk;
          end
        end
        StChk: begin
          r_resp_data <= r_dec_data;
          r_resp_ded  <= 1'b0;
          if (r_special) begin
            r_resp_valid <= 1'b1;
            r_state      <= StRsp;
          end else if (i_dec_double) begin
            r_resp_ded   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= StRsp;
          end else if (i_dec_single) begin
            r_resp_data <= i_dec_corr_data;
            r_wr_data   <= i_dec_corr_data;
            r_wr_req    <= 1'b1;
            r_state     <= StScrub;
          end else begin
            r_resp_valid <= 1'b1;
            r_state      <= StRsp;
          end
        end
        StScrub: begin
          // Response is held back until the repaired word is in the cache.
          if (i_cache_wr_ack) begin
            r_wr_req     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= StRsp;
          end
        end
        StRsp: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase

      // Clear takes priority over a same-cycle increment.
      if (i_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_sec_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_req_ready     = (r_state == StIdle);
  assign o_cache_rd_req  = r_rd_req;
  assign o_cache_rd_addr = r_addr;
  assign o_dec_data      = r_dec_data;
  assign o_dec_parity    = r_dec_parity;
  assign o_cache_wr_req  = r_wr_req;
  assign o_cache_wr_addr = r_addr;
  assign o_cache_wr_data = r_wr_data;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_data     = r_resp_data;
  assign o_resp_ded      = r_resp_ded;
  assign o_sec_count     = r_cnt;

endmodule

// File: tb/tb_ecc_load_ctrl.sv
// Testbench for ecc_load_ctrl: directed loads with scoreboarded responses and scrubs.
// A second instance with a 4-bit counter shares all inputs so saturation is reachable.
module tb_ecc_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        req_special = 1'b0;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_valid = 1'b0;
  logic [31:0] cache_data = '0;
  logic [6:0]  cache_parity = '0;
  logic [31:0] dec_data;
  logic [6:0]  dec_parity;
  logic [31:0] dec_corr_data = '0;
  logic        dec_single = 1'b0;
  logic        dec_double = 1'b0;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_ded;
  logic [15:0] sec_count;
  logic        cnt_clr = 1'b0;

  logic        s_req_ready, s_rd_req, s_wr_req, s_resp_valid, s_resp_ded;
  logic [15:0] s_rd_addr, s_wr_addr;
  logic [31:0] s_dec_data, s_wr_data, s_resp_data;
  logic [6:0]  s_dec_parity;
  logic [3:0]  s_sec_count;

  always #5 clk = ~clk;

  ecc_load_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_special(req_special),
    .o_cache_rd_req(rd_req), .o_cache_rd_addr(rd_addr), .i_cache_rd_valid(rd_valid),
    .i_cache_data(cache_data), .i_cache_parity(cache_parity),
    .o_dec_data(dec_data), .o_dec_parity(dec_parity),
    .i_dec_corr_data(dec_corr_data), .i_dec_single(dec_single), .i_dec_double(dec_double),
    .o_cache_wr_req(wr_req), .o_cache_wr_addr(wr_addr), .o_cache_wr_data(wr_data),
    .i_cache_wr_ack(wr_ack),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_data(resp_data), .o_resp_ded(resp_ded),
    .o_sec_count(sec_count), .i_cnt_clr(cnt_clr)
  );

  ecc_load_ctrl #(.CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(s_req_ready),
    .i_req_addr(req_addr), .i_req_special(req_special),
    .o_cache_rd_req(s_rd_req), .o_cache_rd_addr(s_rd_addr), .i_cache_rd_valid(rd_valid),
    .i_cache_data(cache_data), .i_cache_parity(cache_parity),
    .o_dec_data(s_dec_data), .o_dec_parity(s_dec_parity),
    .i_dec_corr_data(dec_corr_data), .i_dec_single(dec_single), .i_dec_double(dec_double),
    .o_cache_wr_req(s_wr_req), .o_cache_wr_addr(s_wr_addr), .o_cache_wr_data(s_wr_data),
    .i_cache_wr_ack(wr_ack),
    .o_resp_valid(s_resp_valid), .i_resp_ready(resp_ready),
    .o_resp_data(s_resp_data), .o_resp_ded(s_resp_ded),
    .o_sec_count(s_sec_count), .i_cnt_clr(cnt_clr)
  );

  typedef struct {logic [31:0] data; logic ded;} rsp_t;
  typedef struct {logic [15:0] addr; logic [31:0] data;} wr_t;
  rsp_t q_rsp[$];
  wr_t  q_wr[$];

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_cnt = '0;
  logic [3:0]  exp_sat = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever a handshake completes on the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid && resp_ready) begin
        if (q_rsp.size() == 0) begin
          chk("unexpected response", 64'(resp_valid), 64'd0);
        end else begin
          rsp_t e;
          e = q_rsp.pop_front();
          chk("resp_data", 64'(resp_data), 64'(e.data));
          chk("resp_ded", 64'(resp_ded), 64'(e.ded));
        end
      end
      if (wr_req && wr_ack) begin
        if (q_wr.size() == 0) begin
          chk("unexpected scrub", 64'(wr_req), 64'd0);
        end else begin
          wr_t w;
          w = q_wr.pop_front();
          chk("scrub addr", 64'(wr_addr), 64'(w.addr));
          chk("scrub data", 64'(wr_data), 64'(w.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete load; expected behaviour derived from the flags as the
  // controller contract describes.
  task automatic load(input logic [15:0] addr, input logic [31:0] raw, input logic [6:0] par,
                      input logic sgl, input logic dbl, input logic [31:0] corr,
                      input logic special, input int ack_dly, input int bp, input logic clr);
    logic        scrub;
    logic [31:0] edata;
    logic        eded;
    rsp_t        r;
    wr_t         w;
    scrub = !special && !dbl && sgl;
    edata = scrub ? corr : raw;
    eded  = !special && dbl;
    r.data = edata; r.ded = eded; q_rsp.push_back(r);
    if (scrub) begin
      w.addr = addr; w.data = corr; q_wr.push_back(w);
    end
    if (clr) begin
      exp_cnt = '0; exp_sat = '0;
    end else if (scrub) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
      if (exp_sat != 4'hF) exp_sat = exp_sat + 1'b1;
    end
    // cycle 0: request
    dec_single = sgl; dec_double = dbl; dec_corr_data = corr;
    req_addr = addr; req_special = special; req_valid = 1'b1;
    chk("req_ready idle", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    // cycle 1: read
    chk("rd_req", 64'(rd_req), 64'd1);
    chk("rd_addr", 64'(rd_addr), 64'(addr));
    rd_valid = 1'b1; cache_data = raw; cache_parity = par;
    step();
    rd_valid = 1'b0; cache_data = '0; cache_parity = '0;
    // cycle 2: check
    chk("dec_data", 64'(dec_data), 64'(raw));
    chk("dec_parity", 64'(dec_parity), 64'(par));
    chk("rd_req dropped", 64'(rd_req), 64'd0);
    cnt_clr = clr;
    step();
    cnt_clr = 1'b0;
    // cycle 3
    if (scrub) begin
      chk("scrub wr_req", 64'(wr_req), 64'd1);
      chk("no resp in scrub", 64'(resp_valid), 64'd0);
      for (int i = 0; i < ack_dly; i++) begin
        step();
        chk("scrub wr_req held", 64'(wr_req), 64'd1);
        chk("scrub wr_data held", 64'(wr_data), 64'(corr));
        chk("no resp in scrub", 64'(resp_valid), 64'd0);
      end
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
    end
    chk("wr_req low", 64'(wr_req), 64'd0);
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("req_ready busy", 64'(req_ready), 64'd0);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp resp_valid", 64'(resp_valid), 64'd1);
      chk("bp resp_data", 64'(resp_data), 64'(edata));
      chk("bp resp_ded", 64'(resp_ded), 64'(eded));
      chk("bp req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_valid dropped", 64'(resp_valid), 64'd0);
    chk("req_ready after rsp", 64'(req_ready), 64'd1);
    chk("sec_count", 64'(sec_count), 64'(exp_cnt));
    chk("sec_count 4b", 64'(s_sec_count), 64'(exp_sat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst rd_req", 64'(rd_req), 64'd0);
    chk("rst wr_req", 64'(wr_req), 64'd0);
    chk("rst sec_count", 64'(sec_count), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // clean, single (ack after 3), double, special+single, clean with backpressure
    load(16'h0010, 32'hDEADBEEF, 7'h15, 1'b0, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0);
    load(16'h0020, 32'h1234567C, 7'h2A, 1'b1, 1'b0, 32'h12345678, 1'b0, 3, 0, 1'b0);
    load(16'h0030, 32'hFFFF0000, 7'h7F, 1'b0, 1'b1, 32'hFFFF0001, 1'b0, 0, 0, 1'b0);
    load(16'h0044, 32'hCAFEF00D, 7'h01, 1'b1, 1'b0, 32'hCAFEF00C, 1'b1, 0, 0, 1'b0);
    load(16'h0050, 32'hA5A55A5A, 7'h33, 1'b0, 1'b0, 32'h0, 1'b0, 0, 5, 1'b0);

    // saturation: 16 corrections on the 4-bit instance must stop at 0xF
    for (int i = 0; i < 16; i++) begin
      load(16'(16'h0100 + i), 32'h0F0F0F0E, 7'h0C, 1'b1, 1'b0, 32'h0F0F0F0F, 1'b0, 0, 0,
           1'b0);
    end
    // clear coinciding with an increment
    load(16'h0200, 32'h00000001, 7'h04, 1'b1, 1'b0, 32'h00000000, 1'b0, 1, 0, 1'b1);
    load(16'h0204, 32'h80000000, 7'h05, 1'b1, 1'b0, 32'h00000000, 1'b0, 0, 0, 1'b0);

    // reset while a scrub is outstanding
    dec_single = 1'b1; dec_double = 1'b0; dec_corr_data = 32'h55AA55AA;
    req_addr = 16'h0300; req_special = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    rd_valid = 1'b1; cache_data = 32'h55AA55AB; cache_parity = 7'h11;
    step();
    rd_valid = 1'b0;
    step();
    chk("pre-reset wr_req", 64'(wr_req), 64'd1);
    #2;
    rst_n = 1'b0;
    exp_cnt = '0; exp_sat = '0;
    #1;
    chk("mid rst wr_req", 64'(wr_req), 64'd0);
    chk("mid rst wr_addr", 64'(wr_addr), 64'd0);
    chk("mid rst wr_data", 64'(wr_data), 64'd0);
    chk("mid rst rd_req", 64'(rd_req), 64'd0);
    chk("mid rst resp_valid", 64'(resp_valid), 64'd0);
    chk("mid rst resp_data", 64'(resp_data), 64'd0);
    chk("mid rst dec_data", 64'(dec_data), 64'd0);
    chk("mid rst sec_count", 64'(sec_count), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post rst req_ready", 64'(req_ready), 64'd1);
    chk("post rst wr_req", 64'(wr_req), 64'd0);
    load(16'h0310, 32'h13579BDF, 7'h22, 1'b0, 1'b0, 32'h0, 1'b0, 0, 0, 1'b0);

    step();
    chk("rsp queue drained", 64'(q_rsp.size()), 64'd0);
    chk("scrub queue drained", 64'(q_wr.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
